// File: rtl/led_pio_pkg.sv
// led_pio_pkg: register map and bus width shared by the LED PIO blocks.
package led_pio_pkg;
  localparam int DATA_W = 32;
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_MASK   = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_TOGGLE = 3'd5;
endpackage

// File: rtl/led_blink_timer.sv
// led_blink_timer: down-counter prescaler producing the blink phase.
module led_blink_timer #(
  parameter int PRESC_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PRESC_W-1:0] period_i,
  input  logic               load_i,
  output logic               phase_o
);
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic               idle, wrap;
  assign idle = period_i == '0;
  assign wrap = cnt_q == '0;
  // a load restarts the count with the new period; a zero period parks the timer
  always_comb begin
    cnt_d   = load_i ? period_i : idle ? '0 : wrap ? period_i : cnt_q - PRESC_W'(1);
    phase_d = load_i ? 1'b0 : idle ? 1'b0 : wrap ? ~phase_q : phase_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  assign phase_o = phase_q;
endmodule

// File: rtl/led_pio_blink.sv
// led_pio_blink: Avalon-MM output PIO with set/clear registers and per-bit blink.
// Define LED_PIO_TOGGLE_EN to add the write-1-to-toggle register at address 5.
module led_pio_blink
  import led_pio_pkg::*;
#(
  parameter int               WIDTH       = 9,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PRESC_W     = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [WIDTH-1:0]  out_port
);
  logic [WIDTH-1:0]   data_q, data_d, mask_q, mask_d, wd;
  logic [PRESC_W-1:0] period_q, period_d;
  logic               wr, period_ld, phase;
  logic               unused_wd;
  assign wr        = chipselect && !write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = &{1'b0, writedata};
  assign period_ld = wr && address == ADDR_PERIOD;
  assign mask_d    = (wr && address == ADDR_MASK) ? wd : mask_q;
  assign period_d  = period_ld ? writedata[PRESC_W-1:0] : period_q;
  always_comb begin
    data_d = data_q;
    if (wr && address == ADDR_DATA) data_d = wd;
    if (wr && address == ADDR_SET) data_d = data_q | wd;
    if (wr && address == ADDR_CLR) data_d = data_q & ~wd;
`ifdef LED_PIO_TOGGLE_EN
    if (wr && address == ADDR_TOGGLE) data_d = data_q ^ wd;
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      period_q <= '0;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      period_q <= period_d;
    end
  // the timer sees the incoming period on the load edge so the restart uses the new value
  led_blink_timer #(.PRESC_W(PRESC_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .period_i (period_d),
    .load_i   (period_ld),
    .phase_o  (phase)
  );
  always_comb begin
    readdata = '0;
    if (address == ADDR_DATA || address == ADDR_SET || address == ADDR_CLR) readdata = DATA_W'(data_q);
`ifdef LED_PIO_TOGGLE_EN
    if (address == ADDR_TOGGLE) readdata = DATA_W'(data_q);
`endif
    if (address == ADDR_MASK) readdata = DATA_W'(mask_q);
    if (address == ADDR_PERIOD) readdata = DATA_W'(period_q);
  end
  assign out_port = data_q & ~(mask_q & {WIDTH{phase}});
endmodule

// File: tb/tb_led_pio_blink.sv
// tb_led_pio_blink: directed stimulus with a queued scoreboard checked by a monitor.
module tb_led_pio_blink;
  logic        clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write_n = 1'b1;
  logic [2:0]  address = 3'd0;
  logic [31:0] writedata = '0, readdata;
  logic [8:0]  out_port;
  logic        req = 1'b0;
  int          checks = 0, failures = 0;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic [8:0]  op;
  } exp_t;
  exp_t q[$];

  led_pio_blink #(.WIDTH(9), .RESET_VALUE(9'h0A5), .PRESC_W(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (req) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty: monitor had no expected entry");
      end else begin
        exp_t e;
        e = q.pop_front();
        checks += 2;
        if (readdata !== e.rd) begin
          failures++;
          $display("FAIL %s readdata: got %h want %h", e.name, readdata, e.rd);
        end
        if (out_port !== e.op) begin
          failures++;
          $display("FAIL %s out_port: got %h want %h", e.name, out_port, e.op);
        end
      end
    end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic chk(input string name, input logic [2:0] a, input logic [8:0] op, input logic [31:0] rd);
    exp_t e;
    e.name = name; e.rd = rd; e.op = op;
    address = a;
    q.push_back(e);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", 3'd0, 9'h0A5, 32'h0A5);
    reset = 1'b0;
    chk("reset_rd0", 3'd0, 9'h0A5, 32'h0A5);
    chk("reset_rd3", 3'd3, 9'h0A5, 32'h0);
    chk("reset_rd4", 3'd4, 9'h0A5, 32'h0);
    // set/clear with junk in the upper writedata bits
    wr(3'd0, 32'hFFFF_F0F0);
    wr(3'd1, 32'hFFFF_FE03);
    wr(3'd2, 32'hABCD_E010);
    chk("setclr_rd0", 3'd0, 9'h0E3, 32'h0E3);
    chk("setclr_rd1", 3'd1, 9'h0E3, 32'h0E3);
    chk("setclr_rd2", 3'd2, 9'h0E3, 32'h0E3);
    wr(3'd6, 32'h0000_00FF);
    chk("rsvd_rd6", 3'd6, 9'h0E3, 32'h0);
    chk("rsvd_rd7", 3'd7, 9'h0E3, 32'h0);
    wr(3'd5, 32'h0000_0101);
`ifdef LED_PIO_TOGGLE_EN
    chk("toggle_rd5", 3'd5, 9'h1E2, 32'h1E2);
    chk("toggle_rd0", 3'd0, 9'h1E2, 32'h1E2);
`else
    chk("toggle_rd5", 3'd5, 9'h0E3, 32'h0);
    chk("toggle_rd0", 3'd0, 9'h0E3, 32'h0E3);
`endif
    // blink: period 3 -> phase flips every 4 edges
    wr(3'd0, 32'h0000_01FF);
    wr(3'd3, 32'hFFFF_F005);
    chk("mask_rd3", 3'd3, 9'h1FF, 32'h005);
    wr(3'd4, 32'hFF00_0003);
    for (int k = 0; k < 12; k++)
      chk($sformatf("blink_k%0d", k), 3'd0, ((k / 4) % 2) ? 9'h1FA : 9'h1FF, 32'h1FF);
    wr(3'd4, 32'h0);
    chk("period0_a", 3'd4, 9'h1FF, 32'h0);
    chk("period0_b", 3'd0, 9'h1FF, 32'h1FF);
    chk("period0_c", 3'd0, 9'h1FF, 32'h1FF);
    wr(3'd4, 32'h3);
    chk("period3_rd4", 3'd4, 9'h1FF, 32'h3);
    for (int k = 1; k < 6; k++)
      chk($sformatf("resume_k%0d", k), 3'd0, (k >= 4) ? 9'h1FA : 9'h1FF, 32'h1FF);
    // mid-phase rewrite restarts the count with phase cleared
    wr(3'd4, 32'h3);
    for (int k = 0; k < 6; k++)
      chk($sformatf("restart_k%0d", k), 3'd0, (k >= 4) ? 9'h1FA : 9'h1FF, 32'h1FF);
    // asynchronous reset mid-blink
    reset = 1'b1;
    #1;
    chk("areset_rd0", 3'd0, 9'h0A5, 32'h0A5);
    reset = 1'b0;
    chk("areset_rd3", 3'd3, 9'h0A5, 32'h0);
    chk("areset_rd4", 3'd4, 9'h0A5, 32'h0);
    for (int k = 0; k < 6; k++)
      chk($sformatf("noblink_k%0d", k), 3'd0, 9'h0A5, 32'h0A5);
    @(posedge clk); #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
